// File: rtl/round_tracker.sv
// Duck-hunt round tracker: debounces the zapper trigger into shot pulses and
// sequences ducks through flight and result pauses for one game.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_WAIT   | idle before a game; a shot in Start requests start_pulse
// S_FLY    | a duck is in flight, shots and frame ticks are counted
// S_RESULT | pause after a duck, shots ignored, frame ticks counted
// S_OVER   | game finished or aborted, counters frozen until RESET
module round_tracker #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int DUCKS_PER_GAME  = 10,
  parameter int FLY_FRAMES      = 300,
  parameter int RESULT_FRAMES   = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] state,
  input  logic       trigger,
  input  logic       hit,
  input  logic       frame_tick,
  output logic       start_pulse,
  output logic       done_pulse,
  output logic       shot,
  output logic       duck_active,
  output logic       duck_hit,
  output logic       duck_escaped,
  output logic [1:0] shots_left,
  output logic [3:0] ducks_hit,
  output logic [3:0] duck_index
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(FLY_FRAMES + 1);
  localparam int RW = $clog2(RESULT_FRAMES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FLY_LAST = FW'(FLY_FRAMES);
  localparam logic [RW-1:0] RES_LAST = RW'(RESULT_FRAMES);
  localparam logic [1:0]    SHOTS_L  = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0]    DUCKS_L  = 4'(DUCKS_PER_GAME);

  typedef enum logic [1:0] {S_WAIT, S_FLY, S_RESULT, S_OVER} st_e;

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          shot_q;

  st_e           st_q, st_d;
  logic [1:0]    sl_q, sl_d;
  logic [3:0]    dh_q, dh_d;
  logic [3:0]    di_q, di_d;
  logic [FW-1:0] fc_q, fc_d, fc_inc;
  logic [RW-1:0] rc_q, rc_d, rc_inc;
  logic          act_q, act_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          hit_q, hit_d;
  logic          esc_q, esc_d;
  logic          launch, ended;

  logic is_start, is_game, is_done;
  assign is_start = (state == 2'b00) || (state == 2'b11);
  assign is_game  = (state == 2'b01);
  assign is_done  = (state == 2'b10);

  assign fc_inc = fc_q + 1'b1;
  assign rc_inc = rc_q + 1'b1;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      shot_q    <= 1'b0;
    end else begin
      sync1_q   <= trigger;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      shot_q    <= deb_d & ~deb_q;
    end
  end

  always_comb begin
    st_d    = st_q;
    sl_d    = sl_q;
    dh_d    = dh_q;
    di_d    = di_q;
    fc_d    = fc_q;
    rc_d    = rc_q;
    act_d   = act_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    hit_d   = 1'b0;
    esc_d   = 1'b0;
    launch  = 1'b0;
    ended   = 1'b0;
    case (st_q)
      S_WAIT: begin
        if (is_start && shot_q) begin
          start_d = 1'b1;
          dh_d    = '0;
          di_d    = '0;
        end else if (is_game) begin
          launch = 1'b1;
        end
      end
      S_FLY: begin
        if (is_done) begin
          st_d  = S_OVER;
          act_d = 1'b0;
        end else begin
          // the shot is resolved before the flight timeout of the same cycle
          if (shot_q) begin
            sl_d = (sl_q != 2'd0) ? sl_q - 2'd1 : 2'd0;
            if (hit) begin
              dh_d  = (dh_q < DUCKS_L) ? dh_q + 4'd1 : dh_q;
              hit_d = 1'b1;
              ended = 1'b1;
            end else if (sl_q <= 2'd1) begin
              esc_d = 1'b1;
              ended = 1'b1;
            end
          end
          if (frame_tick && !ended) begin
            fc_d = fc_inc;
            if (fc_inc == FLY_LAST) begin
              esc_d = 1'b1;
              ended = 1'b1;
            end
          end
          if (ended) begin
            st_d  = S_RESULT;
            act_d = 1'b0;
            rc_d  = '0;
          end
        end
      end
      S_RESULT: begin
        if (is_done) begin
          st_d = S_OVER;
        end else if (frame_tick) begin
          rc_d = rc_inc;
          if (rc_inc == RES_LAST) begin
            if (di_q == DUCKS_L) begin
              done_d = 1'b1;
              st_d   = S_OVER;
            end else begin
              launch = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    if (launch) begin
      st_d  = S_FLY;
      di_d  = (di_q < DUCKS_L) ? di_q + 4'd1 : di_q;
      sl_d  = SHOTS_L;
      fc_d  = '0;
      act_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q    <= S_WAIT;
      sl_q    <= '0;
      dh_q    <= '0;
      di_q    <= '0;
      fc_q    <= '0;
      rc_q    <= '0;
      act_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      esc_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      sl_q    <= sl_d;
      dh_q    <= dh_d;
      di_q    <= di_d;
      fc_q    <= fc_d;
      rc_q    <= rc_d;
      act_q   <= act_d;
      start_q <= start_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      esc_q   <= esc_d;
    end
  end

  assign shot         = shot_q;
  assign start_pulse  = start_q;
  assign done_pulse   = done_q;
  assign duck_hit     = hit_q;
  assign duck_escaped = esc_q;
  assign duck_active  = act_q;
  assign shots_left   = sl_q;
  assign ducks_hit    = dh_q;
  assign duck_index   = di_q;

endmodule

// File: tb/tb_round_tracker.sv
// Scoreboard bench for round_tracker: expected pulse snapshots are queued by
// the stimulus and popped by a monitor whenever any pulse output is high.
module tb_round_tracker;

  logic       CLK = 1'b0;
  logic       RESET, trigger, hit, frame_tick;
  logic [1:0] state;
  logic       start_pulse, done_pulse, shot, duck_active, duck_hit, duck_escaped;
  logic [1:0] shots_left;
  logic [3:0] ducks_hit, duck_index;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  localparam int P_SHOT  = 16;
  localparam int P_START = 8;
  localparam int P_DONE  = 4;
  localparam int P_HIT   = 2;
  localparam int P_ESC   = 1;

  round_tracker #(
    .DEBOUNCE_CYCLES(4), .SHOTS_PER_DUCK(3), .DUCKS_PER_GAME(2),
    .FLY_FRAMES(5), .RESULT_FRAMES(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .state(state), .trigger(trigger), .hit(hit),
    .frame_tick(frame_tick), .start_pulse(start_pulse), .done_pulse(done_pulse),
    .shot(shot), .duck_active(duck_active), .duck_hit(duck_hit),
    .duck_escaped(duck_escaped), .shots_left(shots_left), .ducks_hit(ducks_hit),
    .duck_index(duck_index)
  );

  always #5 CLK = ~CLK;

  // {pulses[4:0], shots_left, ducks_hit, duck_index, duck_active}
  function automatic logic [15:0] rec(int p, int sl, int dh, int di, int act);
    return {5'(p), 2'(sl), 4'(dh), 4'(di), 1'(act)};
  endfunction

  function automatic logic [15:0] snap();
    return {shot, start_pulse, done_pulse, duck_hit, duck_escaped,
            shots_left, ducks_hit, duck_index, duck_active};
  endfunction

  always @(negedge CLK) begin
    logic [15:0] got, want;
    got = snap();
    if (got[15:11] != 5'd0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse t=%0t got=%h required=no pulse", $time, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL pulse_event t=%0t got=%h required=%h", $time, got, want);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h required=%h", nm, $time, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic h);
    hit = h;
    trigger = 1'b1;
    tick(10);
    trigger = 1'b0;
    tick(10);
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    tick(1);
  endtask

  task automatic reset_cycle();
    RESET = 1'b1;
    state = 2'b00;
    tick(1);
    chk("reset_outputs", snap(), 16'h0);
    tick(1);
    RESET = 1'b0;
    tick(1);
    chk("post_reset_quiet", snap(), 16'h0);
  endtask

  // Shot lands in the same cycle as a frame tick.
  task automatic shot_with_tick();
    bit found = 1'b0;
    hit = 1'b1;
    trigger = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (shot) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL shot_timeout t=%0t got=no shot required=shot within 20 cycles", $time);
    end
    frame_tick = 1'b1;
    @(posedge CLK);
    #1;
    frame_tick = 1'b0;
    trigger = 1'b0;
    tick(10);
  endtask

  initial begin
    RESET = 1'b1; state = 2'b00; trigger = 1'b0; hit = 1'b0; frame_tick = 1'b0;
    tick(3);
    chk("reset_state", snap(), 16'h0);
    RESET = 1'b0;
    tick(1);
    chk("post_reset_quiet", snap(), 16'h0);

    trigger = 1'b1;
    tick(3);
    trigger = 1'b0;
    tick(12);
    chk("glitch_ignored", snap(), 16'h0);

    // game 1: duck 1 hit, duck 2 escapes after three misses
    exp_q.push_back(rec(P_SHOT, 0, 0, 0, 0));
    exp_q.push_back(rec(P_START, 0, 0, 0, 0));
    press(1'b0);
    state = 2'b01;
    tick(2);
    chk("launch_duck1", snap(), rec(0, 3, 0, 1, 1));
    exp_q.push_back(rec(P_SHOT, 3, 0, 1, 1));
    exp_q.push_back(rec(P_HIT, 2, 1, 1, 0));
    press(1'b1);
    chk("result_inactive", snap(), rec(0, 2, 1, 1, 0));
    frame();
    chk("result_one_frame", snap(), rec(0, 2, 1, 1, 0));
    frame();
    chk("launch_duck2", snap(), rec(0, 3, 1, 2, 1));
    exp_q.push_back(rec(P_SHOT, 3, 1, 2, 1));
    press(1'b0);
    chk("miss_1", snap(), rec(0, 2, 1, 2, 1));
    exp_q.push_back(rec(P_SHOT, 2, 1, 2, 1));
    press(1'b0);
    chk("miss_2", snap(), rec(0, 1, 1, 2, 1));
    exp_q.push_back(rec(P_SHOT, 1, 1, 2, 1));
    exp_q.push_back(rec(P_ESC, 0, 1, 2, 0));
    press(1'b0);
    exp_q.push_back(rec(P_DONE, 0, 1, 2, 0));
    frame();
    frame();
    exp_q.push_back(rec(P_SHOT, 0, 1, 2, 0));
    press(1'b1);
    frame();
    chk("over_holds", snap(), rec(0, 0, 1, 2, 0));

    // game 2: timeout escape, then shot coinciding with the last flight frame
    reset_cycle();
    exp_q.push_back(rec(P_SHOT, 0, 0, 0, 0));
    exp_q.push_back(rec(P_START, 0, 0, 0, 0));
    press(1'b0);
    state = 2'b01;
    tick(2);
    repeat (4) frame();
    chk("fly_four_frames", snap(), rec(0, 3, 0, 1, 1));
    exp_q.push_back(rec(P_ESC, 3, 0, 1, 0));
    frame();
    frame();
    frame();
    chk("launch_after_timeout", snap(), rec(0, 3, 0, 2, 1));
    repeat (4) frame();
    exp_q.push_back(rec(P_SHOT, 3, 0, 2, 1));
    exp_q.push_back(rec(P_HIT, 2, 1, 2, 0));
    shot_with_tick();
    chk("hit_beats_timeout", snap(), rec(0, 2, 1, 2, 0));
    exp_q.push_back(rec(P_DONE, 2, 1, 2, 0));
    frame();
    frame();

    // game 3: reset in flight while the trigger is mid-debounce
    reset_cycle();
    exp_q.push_back(rec(P_SHOT, 0, 0, 0, 0));
    exp_q.push_back(rec(P_START, 0, 0, 0, 0));
    press(1'b0);
    state = 2'b01;
    tick(2);
    frame();
    trigger = 1'b1;
    tick(3);
    RESET = 1'b1;
    tick(1);
    chk("reset_midflight", snap(), 16'h0);
    trigger = 1'b0;
    state = 2'b00;
    tick(2);
    RESET = 1'b0;
    tick(1);
    chk("post_reset_quiet", snap(), 16'h0);
    tick(10);

    // game 4: Done state aborts a flying duck without done_pulse
    exp_q.push_back(rec(P_SHOT, 0, 0, 0, 0));
    exp_q.push_back(rec(P_START, 0, 0, 0, 0));
    press(1'b0);
    state = 2'b01;
    tick(2);
    state = 2'b10;
    tick(1);
    chk("abort_to_over", snap(), rec(0, 3, 0, 1, 0));
    exp_q.push_back(rec(P_SHOT, 3, 0, 1, 0));
    press(1'b1);
    chk("abort_holds", snap(), rec(0, 3, 0, 1, 0));

    tick(5);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
